// File: rtl/phase_sequencer_pkg.sv
// Types and constants shared by the phase sequencer and its sub-module.
`include "variables.vh"

package phase_sequencer_pkg;
   localparam int PHASE_W = `PHASEWIDTH;
   localparam int WAIT_W  = 8;

   typedef enum logic [`PHASEWIDTH-1:0] {
      ST_IDLE = `PH_IDLE,
      ST_IF   = `PH_IF,
      ST_ID   = `PH_ID,
      ST_EX   = `PH_EX,
      ST_MEM  = `PH_MEM,
      ST_WB   = `PH_WB,
      ST_HALT = `PH_HALT
   } phase_e;
endpackage

// File: rtl/phase_sequencer_edge_detect.sv
// edge_detect: registered rising-edge detector producing a one-cycle pulse.
module edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic sig_in,
   output logic pulse_out
);
   logic sig_prev_q, sig_prev_d;
   logic pulse_q, pulse_d;

   always_comb begin
      sig_prev_d = sig_in;
      pulse_d    = sig_in & ~sig_prev_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sig_prev_q <= 1'b0;
         pulse_q    <= 1'b0;
      end else begin
         sig_prev_q <= sig_prev_d;
         pulse_q    <= pulse_d;
      end
   end

   assign pulse_out = pulse_q;
endmodule

// File: rtl/variables.vh
// Shared phase encodings for the instruction phase sequencer.
`ifndef VARIABLES_VH
`define VARIABLES_VH
`define PHASEWIDTH 3
`define PH_IDLE 3'd0
`define PH_IF   3'd1
`define PH_ID   3'd2
`define PH_EX   3'd3
`define PH_MEM  3'd4
`define PH_WB   3'd5
`define PH_HALT 3'd6
`endif

// File: rtl/phase_sequencer.sv
// Multi-cycle instruction phase sequencer (IF/ID/EX/MEM/WB) with MEM timeout.
// Optional retired-instruction counter output enabled by INSTRET_COUNTER_EN.
module phase_sequencer
   import phase_sequencer_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               run,
   input  logic               step,
   input  logic               is_mem,
   input  logic               mem_ready,
   input  logic               halt_req,
   output logic               if_en,
   output logic               mem_en,
   output logic               wb_en,
   output logic               pc_en,
   output logic [PHASE_W-1:0] phase,
   output logic               halted,
   output logic               timeout_err
`ifdef INSTRET_COUNTER_EN
   ,
   output logic [31:0]        instret
`endif
);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   phase_e            state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              is_mem_q, is_mem_d;
   logic              halted_q, halted_d;
   logic              timeout_q, timeout_d;
   logic              step_pulse;

   edge_detect u_step_edge (
      .clk       (clk),
      .rst       (rst),
      .sig_in    (step),
      .pulse_out (step_pulse)
   );

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      is_mem_d   = is_mem_q;
      halted_d   = halted_q;
      timeout_d  = timeout_q;
      if_en      = 1'b0;
      mem_en     = 1'b0;
      wb_en      = 1'b0;
      pc_en      = 1'b0;
      case (state_q)
         ST_IDLE: if (run || step_pulse) state_d = ST_IF;
         ST_IF: begin
            if_en   = 1'b1;
            state_d = ST_ID;
         end
         ST_ID: begin
            is_mem_d = is_mem;
            state_d  = ST_EX;
         end
         ST_EX: begin
            if (is_mem_q) begin
               state_d    = ST_MEM;
               wait_cnt_d = '0;
            end else begin
               state_d = ST_WB;
            end
         end
         ST_MEM: begin
            mem_en = 1'b1;
            if (mem_ready) begin
               state_d = ST_WB;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
               // This cycle is the MEM_TIMEOUT-th one spent waiting.
               if (wait_cnt_q == WAIT_LAST) begin
                  state_d   = ST_HALT;
                  halted_d  = 1'b1;
                  timeout_d = 1'b1;
               end
            end
         end
         ST_WB: begin
            wb_en = 1'b1;
            pc_en = 1'b1;
            if (halt_req) begin
               state_d  = ST_HALT;
               halted_d = 1'b1;
            end else if (run) begin
               state_d = ST_IF;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         wait_cnt_q <= '0;
         is_mem_q   <= 1'b0;
         halted_q   <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         is_mem_q   <= is_mem_d;
         halted_q   <= halted_d;
         timeout_q  <= timeout_d;
      end
   end

   assign phase       = state_q;
   assign halted      = halted_q;
   assign timeout_err = timeout_q;

`ifdef INSTRET_COUNTER_EN
   logic [31:0] instret_q, instret_d;

   always_comb begin
      instret_d = instret_q;
      if (pc_en) instret_d = instret_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) instret_q <= '0;
      else     instret_q <= instret_d;
   end

   assign instret = instret_q;
`endif
endmodule
